// File: rtl/exec_pkg.sv
// Shared definitions for the execute/writeback stage.
// Holds the data and id widths, the null register id, the opcode constants,
// the FSM state encoding and the opcode classification helper.
package exec_pkg;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned ID_WIDTH = 4;
    localparam int unsigned OP_WIDTH = 4;

    // Writes to this id are discarded by register_block.
    localparam logic [ID_WIDTH-1:0] NULL_REG = ID_WIDTH'(15);

    localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SHL  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SHR  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_LDI  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(10);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Opcodes that produce a result and a write (MUL handled separately).
    function automatic logic is_single_op(input logic [OP_WIDTH-1:0] op);
        return (op >= OP_ADD) && (op <= OP_ADDI);
    endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   start_i           : load a_i/b_i and consume bit 0 of b_i at this edge
//   a_i, b_i          : WIDTH-bit operands
//   done_o            : high for one cycle once product_o is final
//   product_o         : 2*WIDTH-bit product
// The load edge folds in the first iteration, so WIDTH iterations finish
// WIDTH-1 edges after start and done_o is seen on the following cycle.
module shift_add_multiplier
    import exec_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int unsigned CNT_W = 4;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;

    // Iteration datapath; cnt_q counts the remaining multiplier bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
            mcand_q  <= {{(WIDTH-1){1'b0}}, a_i, 1'b0};
            mplier_q <= {1'b0, b_i[WIDTH-1:1]};
            cnt_q    <= CNT_W'(WIDTH - 1);
            done_q   <= 1'b0;
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - CNT_W'(1);
            done_q   <= (cnt_q == CNT_W'(1));
        end else begin
            done_q   <= 1'b0;
        end
    end

    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/execute_unit.sv
// Single-issue execute/writeback stage wrapped around register_block.
// Build option: define EXEC_MUL_EN to make opcode 10 an 8-iteration
// shift-add multiply; otherwise opcode 10 is illegal and acts as NOP.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   instr_valid / instr_ready    : instruction handshake (ready only in IDLE)
//   instr_op/rd/rs1/rs2/imm      : instruction fields
//   read1_id/read1_value         : register_block read port 1
//   read2_id/read2_value         : register_block read port 2
//   write_id/write_value         : register_block write port (NULL_REG when idle)
//   flag_zero, flag_carry        : flags of the last written result
//   busy                         : inverse of instr_ready
module execute_unit
    import exec_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OP_WIDTH-1:0] instr_op,
    input  logic [ID_WIDTH-1:0] instr_rd,
    input  logic [ID_WIDTH-1:0] instr_rs1,
    input  logic [ID_WIDTH-1:0] instr_rs2,
    input  logic [WIDTH-1:0]    instr_imm,
    output logic [ID_WIDTH-1:0] read1_id,
    input  logic [WIDTH-1:0]    read1_value,
    output logic [ID_WIDTH-1:0] read2_id,
    input  logic [WIDTH-1:0]    read2_value,
    output logic [ID_WIDTH-1:0] write_id,
    output logic [WIDTH-1:0]    write_value,
    output logic                flag_zero,
    output logic                flag_carry,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic [ID_WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]    imm_q, imm_d;
    logic [WIDTH-1:0]    opa_q, opa_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic                cry_q, cry_d;
    logic [ID_WIDTH-1:0] rid1_q, rid1_d;
    logic [ID_WIDTH-1:0] rid2_q, rid2_d;
    logic [ID_WIDTH-1:0] wid_q, wid_d;
    logic [WIDTH-1:0]    wval_q, wval_d;
    logic                fz_q, fz_d;
    logic                fc_q, fc_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic [WIDTH-1:0]    alu_res_c;
    logic                alu_cry_c;
    logic                alu_ok_c;
    logic                mul_wait_c;

`ifdef EXEC_MUL_EN
    logic                mul_start_c;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_product;

    // Multiplier starts while operands are on the read ports, so its first
    // iteration lands on the same edge that enters EXEC.
    assign mul_start_c = (state_q == ST_READ) && (op_q == OP_MUL);
    assign mul_wait_c  = (op_q == OP_MUL) && !mul_done;

    shift_add_multiplier u_mul (
        .clock     (clock),
        .reset     (reset),
        .start_i   (mul_start_c),
        .a_i       (read1_value),
        .b_i       (read2_value),
        .done_o    (mul_done),
        .product_o (mul_product)
    );
`else
    assign mul_wait_c = 1'b0;
`endif

    // Result and carry of the latched instruction.
    always_comb begin
        alu_res_c = '0;
        alu_cry_c = 1'b0;
        alu_ok_c  = is_single_op(op_q);
        case (op_q)
            OP_ADD:  {alu_cry_c, alu_res_c} = {1'b0, opa_q} + {1'b0, opb_q};
            OP_SUB: begin
                alu_res_c = opa_q - opb_q;
                alu_cry_c = (opa_q < opb_q);
            end
            OP_AND:  alu_res_c = opa_q & opb_q;
            OP_OR:   alu_res_c = opa_q | opb_q;
            OP_XOR:  alu_res_c = opa_q ^ opb_q;
            OP_SHL:  {alu_cry_c, alu_res_c} = {opa_q, 1'b0};
            OP_SHR:  {alu_res_c, alu_cry_c} = {1'b0, opa_q};
            OP_LDI:  alu_res_c = imm_q;
            OP_ADDI: {alu_cry_c, alu_res_c} = {1'b0, opa_q} + {1'b0, imm_q};
`ifdef EXEC_MUL_EN
            OP_MUL: begin
                alu_res_c = mul_product[WIDTH-1:0];
                alu_cry_c = |mul_product[2*WIDTH-1:WIDTH];
                alu_ok_c  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cry_d   = cry_q;
        rid1_d  = rid1_q;
        rid2_d  = rid2_q;
        wid_d   = NULL_REG;
        wval_d  = '0;
        fz_d    = fz_q;
        fc_d    = fc_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    imm_d   = instr_imm;
                    rid1_d  = instr_rs1;
                    rid2_d  = instr_rs2;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                opa_d   = read1_value;
                opb_d   = read2_value;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (!alu_ok_c) begin
                    // NOP / illegal: no write, flags untouched.
                    rid1_d  = '0;
                    rid2_d  = '0;
                    state_d = ST_IDLE;
                end else if (!mul_wait_c) begin
                    wid_d   = rd_q;
                    wval_d  = alu_res_c;
                    cry_d   = alu_cry_c;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Flags commit on the edge the register block takes the write.
                fz_d    = (wval_q == '0);
                fc_d    = cry_q;
                rid1_d  = '0;
                rid2_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            rd_q    <= '0;
            imm_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cry_q   <= 1'b0;
            rid1_q  <= '0;
            rid2_q  <= '0;
            wid_q   <= NULL_REG;
            wval_q  <= '0;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cry_q   <= cry_d;
            rid1_q  <= rid1_d;
            rid2_q  <= rid2_d;
            wid_q   <= wid_d;
            wval_q  <= wval_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign read1_id    = rid1_q;
    assign read2_id    = rid2_q;
    assign write_id    = wid_q;
    assign write_value = wval_q;
    assign flag_zero   = fz_q;
    assign flag_carry  = fc_q;

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit with a behavioural 16x8 register block attached.
module tb_execute_unit;

    localparam logic [3:0] NULL_ID = 4'd15;
    localparam logic [3:0] O_NOP = 4'd0, O_ADD = 4'd1, O_SUB = 4'd2, O_AND = 4'd3,
                           O_OR = 4'd4, O_XOR = 4'd5, O_SHL = 4'd6, O_SHR = 4'd7,
                           O_LDI = 4'd8, O_ADDI = 4'd9, O_MUL = 4'd10;

    logic       clock;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op, instr_rd, instr_rs1, instr_rs2;
    logic [7:0] instr_imm;
    logic [3:0] read1_id, read2_id, write_id;
    logic [7:0] read1_value, read2_value, write_value;
    logic       flag_zero, flag_carry, busy;

    logic [7:0] rf [16];
    logic       rf_clear;

    int checks = 0;
    int errors = 0;

    // Reference state
    int mrf [16];
    int mz, mc;

    typedef struct packed {
        logic       wr;
        logic [7:0] res;
        logic       c;
        logic [3:0] lat;
    } mres_t;

    typedef struct packed {
        logic [3:0] op, rd, rs1, rs2;
        logic [7:0] imm;
        logic       wr;
        logic [7:0] val;
        logic       z, c;
        logic [3:0] lat;
    } vec_t;

    execute_unit dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .read1_id    (read1_id),
        .read1_value (read1_value),
        .read2_id    (read2_id),
        .read2_value (read2_value),
        .write_id    (write_id),
        .write_value (write_value),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register block: combinational reads, write on rising edge, id 15 discarded.
    assign read1_value = rf[read1_id];
    assign read2_value = rf[read2_id];
    always @(posedge clock) begin
        if (rf_clear) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (write_id != NULL_ID) begin
            rf[write_id] <= write_value;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Specification-level behaviour of one instruction.
    function automatic mres_t ref_model(input int op, input int a, input int b, input int imm);
        mres_t r;
        int v;
        r = '0;
        r.wr = 1'b1;
        r.lat = 4'd3;
        v = 0;
        case (op)
            1: begin v = a + b;       r.c = (v > 255); end
            2: begin v = a - b + 256; r.c = (a < b);   end
            3: v = a & b;
            4: v = a | b;
            5: v = a ^ b;
            6: begin v = a * 2; r.c = (a >= 128); end
            7: begin v = a / 2; r.c = (a % 2 == 1); end
            8: v = imm;
            9: begin v = a + imm; r.c = (v > 255); end
`ifdef EXEC_MUL_EN
            10: begin v = a * b; r.c = (v > 255); r.lat = 4'd10; end
`endif
            default: begin r.wr = 1'b0; r.lat = 4'd0; end
        endcase
        r.res = 8'(v % 256);
        return r;
    endfunction

    task automatic model_commit(input logic [3:0] rd, input mres_t m);
        if (m.wr) begin
            if (rd != NULL_ID) mrf[rd] = int'(m.res);
            mz = (m.res == 8'h00) ? 1 : 0;
            mc = int'(m.c);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, rd, rs1, rs2, input logic [7:0] imm,
                                input logic wr, input logic [7:0] val, input logic z, c,
                                input logic [3:0] lat);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.wr = wr; v.val = val; v.z = z; v.c = c; v.lat = lat;
        return v;
    endfunction

    // Issue one instruction and observe it from the accept edge to IDLE.
    task automatic run_instr(input logic [3:0] op, rd, rs1, rs2, input logic [7:0] imm,
                             output int wr_cnt, output int wr_k, output int wr_val,
                             output int rdy_k, output int rid_ok, output int idle_ok,
                             output int stray);
        int guard;
        wr_cnt = 0; wr_k = 0; wr_val = 0; rdy_k = 0; rid_ok = 0; idle_ok = 0; stray = 0;
        guard = 0;
        @(negedge clock);
        while (!instr_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("accept_wait", int'(instr_ready), 1);
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 1) rid_ok = (read1_id == rs1 && read2_id == rs2) ? 1 : 0;
            if (write_id != NULL_ID) begin
                wr_cnt++;
                wr_k = k;
                wr_val = int'(write_value);
            end else if (write_value != 8'h00 && rd != NULL_ID) begin
                stray++;
            end
            if (instr_ready) begin
                rdy_k = k;
                idle_ok = (read1_id == 4'd0 && read2_id == 4'd0 && !busy) ? 1 : 0;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic verify(input string tag, input logic [3:0] rd, input logic wr,
                          input logic [7:0] val, input logic [3:0] lat, input logic z,
                          input logic c, input int wr_cnt, input int wr_k, input int wr_val,
                          input int rdy_k, input int rid_ok, input int idle_ok, input int stray);
        int vis;
        vis = (wr && rd != NULL_ID) ? 1 : 0;
        check({tag, ".write_count"}, wr_cnt, vis);
        if (vis == 1) begin
            check({tag, ".write_cycle"}, wr_k, int'(lat));
            check({tag, ".write_value"}, wr_val, int'(val));
            check({tag, ".reg_value"}, int'(rf[rd]), int'(val));
        end
        check({tag, ".ready_cycle"}, rdy_k, wr ? int'(lat) + 1 : 3);
        check({tag, ".flag_zero"}, int'(flag_zero), int'(z));
        check({tag, ".flag_carry"}, int'(flag_carry), int'(c));
        check({tag, ".read_ids"}, rid_ok, 1);
        check({tag, ".idle_outputs"}, idle_ok, 1);
        check({tag, ".stray_write_value"}, stray, 0);
    endtask

    vec_t tbl [19];

    initial begin
        int wc, wk, wv, rk, ro, io, st;
        int acc_k, guard, nulls;
        mres_t m;
        logic [3:0] op, rd, rs1, rs2;
        logic [7:0] imm;

        for (int i = 0; i < 16; i++) mrf[i] = 0;
        mz = 0; mc = 0;
        reset = 1'b1; rf_clear = 1'b1; instr_valid = 1'b0;
        instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0; rf_clear = 1'b0;

        check("reset.write_id", int'(write_id), 15);
        check("reset.write_value", int'(write_value), 0);
        check("reset.read_ids", int'({read1_id, read2_id}), 0);
        check("reset.flags", int'({flag_zero, flag_carry}), 0);
        check("reset.ready", int'(instr_ready), 1);
        check("reset.busy", int'(busy), 0);

        tbl[0]  = mk(O_LDI,  4'd2,  4'd0, 4'd0, 8'h55, 1, 8'h55, 0, 0, 4'd3);
        tbl[1]  = mk(O_LDI,  4'd1,  4'd0, 4'd0, 8'hF0, 1, 8'hF0, 0, 0, 4'd3);
        tbl[2]  = mk(O_LDI,  4'd2,  4'd0, 4'd0, 8'h20, 1, 8'h20, 0, 0, 4'd3);
        tbl[3]  = mk(O_ADD,  4'd3,  4'd1, 4'd2, 8'h00, 1, 8'h10, 0, 1, 4'd3);
        tbl[4]  = mk(O_SUB,  4'd4,  4'd2, 4'd1, 8'h00, 1, 8'h30, 0, 1, 4'd3);
        tbl[5]  = mk(O_LDI,  4'd1,  4'd0, 4'd0, 8'h0F, 1, 8'h0F, 0, 0, 4'd3);
        tbl[6]  = mk(O_XOR,  4'd5,  4'd1, 4'd1, 8'h00, 1, 8'h00, 1, 0, 4'd3);
        tbl[7]  = mk(O_SHL,  4'd8,  4'd1, 4'd0, 8'h00, 1, 8'h1E, 0, 0, 4'd3);
        tbl[8]  = mk(O_SHR,  4'd9,  4'd1, 4'd0, 8'h00, 1, 8'h07, 0, 1, 4'd3);
        tbl[9]  = mk(O_AND,  4'd10, 4'd3, 4'd4, 8'h00, 1, 8'h10, 0, 0, 4'd3);
        tbl[10] = mk(O_OR,   4'd11, 4'd3, 4'd4, 8'h00, 1, 8'h30, 0, 0, 4'd3);
        tbl[11] = mk(O_ADDI, 4'd12, 4'd1, 4'd0, 8'hF1, 1, 8'h00, 1, 1, 4'd3);
        tbl[12] = mk(O_NOP,  4'd13, 4'd1, 4'd2, 8'h44, 0, 8'h00, 1, 1, 4'd0);
        tbl[13] = mk(4'd12,  4'd13, 4'd1, 4'd2, 8'h44, 0, 8'h00, 1, 1, 4'd0);
        tbl[14] = mk(O_LDI,  4'd1,  4'd0, 4'd0, 8'h12, 1, 8'h12, 0, 0, 4'd3);
        tbl[15] = mk(O_LDI,  4'd2,  4'd0, 4'd0, 8'h10, 1, 8'h10, 0, 0, 4'd3);
`ifdef EXEC_MUL_EN
        tbl[16] = mk(O_MUL,  4'd6,  4'd1, 4'd2, 8'h00, 1, 8'h20, 0, 1, 4'd10);
`else
        tbl[16] = mk(O_MUL,  4'd6,  4'd1, 4'd2, 8'h00, 0, 8'h00, 0, 0, 4'd0);
`endif
        tbl[17] = mk(O_LDI,  4'd15, 4'd0, 4'd0, 8'h00, 1, 8'h00, 1, 0, 4'd3);
        tbl[18] = mk(O_SUB,  4'd13, 4'd2, 4'd2, 8'h00, 1, 8'h00, 1, 0, 4'd3);

        for (int i = 0; i < 19; i++) begin
            m = ref_model(int'(tbl[i].op), mrf[tbl[i].rs1], mrf[tbl[i].rs2], int'(tbl[i].imm));
            run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
                      wc, wk, wv, rk, ro, io, st);
            verify($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].val, tbl[i].lat,
                   tbl[i].z, tbl[i].c, wc, wk, wv, rk, ro, io, st);
            model_commit(tbl[i].rd, m);
        end
        check("vec.null_reg_untouched", int'(rf[15]), 0);

        // Reset while ADD r7 is in EXEC: the write must never happen.
        @(negedge clock);
        instr_valid = 1'b1;
        instr_op = O_ADD; instr_rd = 4'd7; instr_rs1 = 4'd1; instr_rs2 = 4'd2; instr_imm = 8'h00;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset.write_id", int'(write_id), 15);
        check("midreset.write_value", int'(write_value), 0);
        check("midreset.read_ids", int'({read1_id, read2_id}), 0);
        check("midreset.flags", int'({flag_zero, flag_carry}), 0);
        check("midreset.ready", int'(instr_ready), 1);
        check("midreset.busy", int'(busy), 0);
        reset = 1'b0;
        mz = 0; mc = 0;
        nulls = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (write_id == NULL_ID) nulls++;
        end
        check("midreset.no_write_after", nulls, 6);
        check("midreset.r7", int'(rf[7]), 0);

        // Back-to-back: second instruction held valid until the first has written.
        @(negedge clock);
        instr_valid = 1'b1;
        instr_op = O_LDI; instr_rd = 4'd1; instr_rs1 = 4'd0; instr_rs2 = 4'd0; instr_imm = 8'h05;
        @(posedge clock);
        @(negedge clock);
        instr_op = O_ADDI; instr_rd = 4'd1; instr_rs1 = 4'd1; instr_rs2 = 4'd0; instr_imm = 8'h03;
        acc_k = 0;
        for (int k = 1; k <= 20; k++) begin
            if (instr_ready) begin
                acc_k = k;
                break;
            end
            @(negedge clock);
        end
        check("b2b.second_accept_cycle", acc_k, 4);
        check("b2b.first_written", int'(rf[1]), 8'h05);
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        guard = 0;
        while (!instr_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("b2b.finished", int'(instr_ready), 1);
        check("b2b.r1", int'(rf[1]), 8'h08);
        mrf[1] = 8; mz = 0; mc = 0;

        // Randomized instructions against the reference model.
        for (int n = 0; n < 150; n++) begin
            op  = 4'($urandom_range(0, 15));
            rd  = 4'($urandom_range(0, 15));
            rs1 = 4'($urandom_range(0, 15));
            rs2 = 4'($urandom_range(0, 15));
            imm = 8'($urandom_range(0, 255));
            m = ref_model(int'(op), mrf[rs1], mrf[rs2], int'(imm));
            run_instr(op, rd, rs1, rs2, imm, wc, wk, wv, rk, ro, io, st);
            model_commit(rd, m);
            verify($sformatf("rnd%0d_op%0d", n, op), rd, m.wr, m.res, m.lat,
                   logic'(mz), logic'(mc), wc, wk, wv, rk, ro, io, st);
        end

        for (int i = 0; i < 15; i++) begin
            check($sformatf("final.r%0d", i), int'(rf[i]), mrf[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
